btb_2bit_direct: RTL and testbench

- Direct-mapped branch target buffer with per-entry 2-bit saturating direction counters.
- Sits directly upstream of the fetch stage's next-PC mux.
- Prediction is read combinationally from the fetch PC in the same cycle.
- Update is written synchronously from EX-stage branch resolution.
- Supplies predict_valid / predict_taken / predict_target, which the fetch stage ANDs and muxes into next PC.

---
 rtl/btb_2bit_direct_if.sv | 36 +++
 rtl/btb_2bit_direct.sv | 97 +++++++++
 tb/tb_btb_2bit_direct.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/btb_2bit_direct_if.sv
// Fetch/EX-facing bundle of the branch target buffer: the combinational lookup
// (PC in, prediction out) and the EX-stage resolution update.
interface btb_2bit_direct_if;
    logic [31:0] pc;
    logic        predict_valid;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        update_en;
    logic [31:0] update_pc;
    logic        actual_taken;
    logic [31:0] update_target;

    // Pipeline side: drives the lookup PC and the resolved branch; consumes the prediction.
    modport master (
        output pc,
        output update_en,
        output update_pc,
        output actual_taken,
        output update_target,
        input  predict_valid,
        input  predict_taken,
        input  predict_target
    );

    // BTB side.
    modport slave (
        input  pc,
        input  update_en,
        input  update_pc,
        input  actual_taken,
        input  update_target,
        output predict_valid,
        output predict_taken,
        output predict_target
    );
endinterface

// File: rtl/btb_2bit_direct.sv
// Direct-mapped branch target buffer with a 2-bit saturating direction counter
// per entry. The lookup is asynchronous from the fetch PC; updates from EX land
// on the next rising edge, so a same-index lookup sees the pre-update contents.
module btb_2bit_direct #(
    parameter int ENTRIES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    btb_2bit_direct_if.slave     bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    // Per-entry state; tag/target are only meaningful while the valid bit is set.
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;

    // Instruction alignment bits never participate in indexing or tagging.
    logic unused_lsbs;
    assign unused_lsbs = ^{bus.pc[1:0], bus.update_pc[1:0]};

    assign lk_idx = bus.pc[IDX_W+1:2];
    assign lk_tag = bus.pc[31:IDX_W+2];
    assign up_idx = bus.update_pc[IDX_W+1:2];
    assign up_tag = bus.update_pc[31:IDX_W+2];

    // Zero-latency prediction; everything reads 0 on a miss.
    always_comb begin
        lk_hit             = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        bus.predict_valid  = lk_hit;
        bus.predict_taken  = 1'b0;
        bus.predict_target = '0;
        if (lk_hit) begin
            bus.predict_taken  = ctr_q[lk_idx][1];
            bus.predict_target = target_q[lk_idx];
        end
    end

    // Resolution update: train on a hit, allocate only on a taken miss.
    always_comb begin
        valid_d  = valid_q;
        ctr_d    = ctr_q;
        tag_d    = tag_q;
        target_d = target_q;
        up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        if (bus.update_en) begin
            if (up_hit) begin
                if (bus.actual_taken) begin
                    if (ctr_q[up_idx] != 2'b11) begin
                        ctr_d[up_idx] = ctr_q[up_idx] + 2'b01;
                    end
                    target_d[up_idx] = bus.update_target;
                end else if (ctr_q[up_idx] != 2'b00) begin
                    ctr_d[up_idx] = ctr_q[up_idx] - 2'b01;
                end
            end else if (bus.actual_taken) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = bus.update_target;
                ctr_d[up_idx]    = 2'b10;
            end
        end
    end

    // Valid bits and counters: reset empties the table and drops any coincident update.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
        end
    end

    // Tag/target payload: no reset needed, but writes are still blocked during reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_q    <= tag_d;
            target_q <= target_d;
        end
    end
endmodule

// File: tb/tb_btb_2bit_direct.sv
// Self-checking bench for btb_2bit_direct: a behavioural table model plus
// directed expectations feed a queue that is drained against the DUT outputs.
module tb_btb_2bit_direct;
    typedef struct {
        string       tag;
        logic        valid;
        logic        taken;
        logic [31:0] target;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    // Reference table (ENTRIES = 16: index pc[5:2], tag pc[31:6]).
    bit          m_valid  [16];
    logic [25:0] m_tag    [16];
    logic [31:0] m_target [16];
    int          m_ctr    [16];

    btb_2bit_direct_if bus();

    btb_2bit_direct #(.ENTRIES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
    endtask

    task automatic model_update(input logic [31:0] upc, input logic tk, input logic [31:0] tgt);
        int          i;
        logic [25:0] t;
        i = int'(upc[5:2]);
        t = upc[31:6];
        if (m_valid[i] && m_tag[i] == t) begin
            if (tk) begin
                if (m_ctr[i] < 3) m_ctr[i]++;
                m_target[i] = tgt;
            end else if (m_ctr[i] > 0) begin
                m_ctr[i]--;
            end
        end else if (tk) begin
            m_valid[i]  = 1'b1;
            m_tag[i]    = t;
            m_target[i] = tgt;
            m_ctr[i]    = 2;
        end
    endtask

    // One clock: drive at the falling edge, queue expectations, compare mid-cycle,
    // then let the rising edge commit and advance the model.
    task automatic cyc(input logic [31:0] lpc, input logic ue, input logic [31:0] upc,
                       input logic tk, input logic [31:0] tgt, input logic r,
                       input bit dir, input logic dv, input logic dt, input logic [31:0] dtgt,
                       input string name);
        exp_t e;
        int   i;
        @(negedge clk);
        rst               = r;
        bus.pc            = lpc;
        bus.update_en     = ue;
        bus.update_pc     = upc;
        bus.actual_taken  = tk;
        bus.update_target = tgt;
        #1;
        i        = int'(lpc[5:2]);
        e.tag    = {name, "/model"};
        e.valid  = m_valid[i] && (m_tag[i] == lpc[31:6]);
        e.taken  = e.valid && (m_ctr[i] >= 2);
        e.target = e.valid ? m_target[i] : 32'h0;
        sb_q.push_back(e);
        if (dir) begin
            e.tag    = name;
            e.valid  = dv;
            e.taken  = dt;
            e.target = dtgt;
            sb_q.push_back(e);
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.tag, ".valid"},  {31'h0, bus.predict_valid}, {31'h0, e.valid});
            check({e.tag, ".taken"},  {31'h0, bus.predict_taken}, {31'h0, e.taken});
            check({e.tag, ".target"}, bus.predict_target,         e.target);
        end
        @(posedge clk);
        if (r) model_reset();
        else if (ue) model_update(upc, tk, tgt);
    endtask

    task automatic look(input logic [31:0] lpc, input logic dv, input logic dt,
                        input logic [31:0] dtgt, input string name);
        cyc(lpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, dv, dt, dtgt, name);
    endtask

    task automatic upd(input logic [31:0] upc, input logic tk, input logic [31:0] tgt);
        cyc(32'h0, 1'b1, upc, tk, tgt, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "upd");
    endtask

    initial begin
        logic [31:0] a, b;
        model_reset();
        rst = 1'b1;
        bus.pc = '0; bus.update_en = 1'b0; bus.update_pc = '0;
        bus.actual_taken = 1'b0; bus.update_target = '0;
        cyc(32'h40, 1'b1, 32'h40, 1'b1, 32'h999, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, "rst0");
        cyc(32'h40, 1'b0, 32'h0,  1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b0, 32'h0, "rst1");
        look(32'h40, 1'b0, 1'b0, 32'h0, "reset_miss");

        // Allocation with a same-cycle lookup: no bypass.
        cyc(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, "rdw_same");
        look(32'h40, 1'b1, 1'b1, 32'h100, "alloc_wt");

        // Counter walk: 10 -> 01 -> 00 (sat) -> 11 (sat) -> 10 -> 01.
        upd(32'h40, 1'b0, 32'hdead);
        look(32'h40, 1'b1, 1'b0, 32'h100, "ctr_wnt");
        upd(32'h40, 1'b0, 32'hdead);
        upd(32'h40, 1'b0, 32'hdead);
        look(32'h40, 1'b1, 1'b0, 32'h100, "ctr_snt_sat");
        for (int k = 0; k < 4; k++) upd(32'h40, 1'b1, 32'h100);
        look(32'h40, 1'b1, 1'b1, 32'h100, "ctr_st_sat");
        upd(32'h40, 1'b0, 32'hdead);
        look(32'h40, 1'b1, 1'b1, 32'h100, "ctr_st_to_wt");
        upd(32'h40, 1'b0, 32'hdead);
        look(32'h41, 1'b1, 1'b0, 32'h100, "ctr_wt_to_wnt");

        // Index conflict and not-taken miss.
        upd(32'h80, 1'b1, 32'h200);
        look(32'h40, 1'b0, 1'b0, 32'h0,   "conflict_evict");
        look(32'h83, 1'b1, 1'b1, 32'h200, "conflict_new");
        upd(32'h44, 1'b0, 32'h300);
        look(32'h44, 1'b0, 1'b0, 32'h0,   "nt_no_alloc");
        upd(32'h48, 1'b1, 32'h300);
        look(32'h48, 1'b1, 1'b1, 32'h300, "alloc_idx2");

        // Reset mid-operation with a coincident update.
        cyc(32'h80, 1'b1, 32'h40, 1'b1, 32'h500, 1'b1, 1'b1, 1'b1, 1'b1, 32'h200, "rst_mid");
        look(32'h40, 1'b0, 1'b0, 32'h0, "post_rst_40");
        look(32'h80, 1'b0, 1'b0, 32'h0, "post_rst_80");
        look(32'h48, 1'b0, 1'b0, 32'h0, "post_rst_48");
        upd(32'h80, 1'b1, 32'h600);
        look(32'h80, 1'b1, 1'b1, 32'h600, "post_rst_alloc");

        // Random traffic over a few indices and aliasing tags.
        for (int k = 0; k < 400; k++) begin
            a = {$urandom_range(2, 0), 26'h0, 6'h0} | {26'h0, 2'($urandom_range(3, 0)), 2'b00, 2'($urandom_range(3, 0))};
            a = {24'h0, a[31:24] == 8'h0 ? 2'b00 : 2'b00, 6'h0} | {a[31:30], 24'h0, a[5:0]};
            b = {2'($urandom_range(2, 0)), 24'h0, 2'($urandom_range(3, 0)), 2'b00, 2'($urandom_range(3, 0))};
            a = {2'($urandom_range(2, 0)), 24'h0, 2'($urandom_range(3, 0)), 2'b00, 2'($urandom_range(3, 0))};
            cyc(a, 1'($urandom_range(1, 0)), b, 1'($urandom_range(1, 0)), $urandom,
                ($urandom_range(49, 0) == 0), 1'b0, 1'b0, 1'b0, 32'h0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
